// File: rtl/bus_slave_responder_pkg.sv
// Shared definitions for the slave-side serial bus responder: FSM encoding and default widths.
package bus_slave_responder_pkg;

   localparam int unsigned DEFAULT_ADDR_LEN  = 12;
   localparam int unsigned DEFAULT_DATA_LEN  = 8;
   localparam int unsigned DEFAULT_BURST_LEN = 12;
   localparam int unsigned DEFAULT_SPLIT_MIN = 8;
   localparam int unsigned DELAY_W           = 6;

   // Every serial field on this bus travels least-significant bit first.
   localparam bit LSB_FIRST = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StWrite,
      StRdelay,
      StRfetch,
      StRdata
   } state_e;

endpackage

// File: rtl/bus_slave_responder_slave_bram.sv
// Single-port block RAM with synchronous write and registered (1-cycle) read; contents not reset.
module slave_bram #(
   parameter int unsigned ADDR_LEN = 12,
   parameter int unsigned DATA_LEN = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic                re,
   input  logic [ADDR_LEN-1:0] addr,
   input  logic [DATA_LEN-1:0] wdata,
   output logic [DATA_LEN-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_LEN;

   logic [DATA_LEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bus_slave_responder.sv
// Slave-slot responder: deserialises address/burst/write data, serves a local RAM and
// serialises read data back, with an optional per-beat read delay that can signal a split.
module bus_slave_responder
   import bus_slave_responder_pkg::*;
#(
   parameter int unsigned ADDR_LEN  = DEFAULT_ADDR_LEN,
   parameter int unsigned DATA_LEN  = DEFAULT_DATA_LEN,
   parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN,
   parameter int unsigned SPLIT_MIN = DEFAULT_SPLIT_MIN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DELAY_W-1:0] s_slave_delay,
   input  logic               s_read_en,
   input  logic               s_write_en,
   input  logic               s_master_valid,
   input  logic               s_master_ready,
   input  logic               s_rx_address,
   input  logic               s_rx_burst,
   input  logic               s_rx_data,
   output logic               s_slave_ready,
   output logic               s_slave_valid,
   output logic               s_tx_data,
   output logic               s_split_en
);

   localparam int unsigned MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(ADDR_LEN - 1);
   localparam logic [CNT_W-1:0]   DATA_LAST = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0]   BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [DELAY_W-1:0] SPLIT_THR = DELAY_W'(SPLIT_MIN);

   state_e               state_q, state_d;
   logic [ADDR_LEN-1:0]  addr_q, addr_d;
   logic [BURST_LEN-1:0] burst_q, burst_d;
   logic [BURST_LEN-1:0] beats_q, beats_d;
   logic [DATA_LEN-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]     bit_q, bit_d;
   logic [DELAY_W-1:0]   delay_q, delay_d;
   logic                 is_read_q, is_read_d;
   logic                 split_q, split_d;
   logic                 ready_q;

   logic                 take_in;
   logic                 take_out;
   logic                 mem_we;
   logic                 mem_re;
   logic [DATA_LEN-1:0]  rdata;
   logic [DATA_LEN-1:0]  tx_word;
   logic                 tx_bit;

   slave_bram #(
      .ADDR_LEN (ADDR_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_bram (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   assign take_in  = s_master_valid && ready_q;
   assign take_out = s_slave_valid && s_master_ready;

   assign tx_word = LSB_FIRST ? (rdata >> bit_q) : (rdata << bit_q);
   assign tx_bit  = LSB_FIRST ? tx_word[0] : tx_word[DATA_LEN-1];

   assign s_slave_ready = ready_q;
   assign s_slave_valid = (state_q == StRdata);
   assign s_tx_data     = s_slave_valid && tx_bit;
   assign s_split_en    = (state_q == StRdelay) && split_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      burst_d   = burst_q;
      beats_d   = beats_q;
      wdata_d   = wdata_q;
      bit_d     = bit_q;
      delay_d   = delay_q;
      is_read_d = is_read_q;
      split_d   = split_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Bits carrying no or both opcode flags are dropped without leaving IDLE.
            if (take_in && (s_read_en ^ s_write_en)) begin
               is_read_d = s_read_en;
               addr_d    = {s_rx_address, addr_q[ADDR_LEN-1:1]};
               burst_d   = {s_rx_burst, burst_q[BURST_LEN-1:1]};
               bit_d     = CNT_W'(1);
               state_d   = StAddr;
            end
         end
         StAddr: begin
            if (take_in) begin
               addr_d = {s_rx_address, addr_q[ADDR_LEN-1:1]};
               if (bit_q < BURST_CNT) begin
                  burst_d = {s_rx_burst, burst_q[BURST_LEN-1:1]};
               end
               bit_d = bit_q + 1'b1;
               if (bit_q == ADDR_LAST) begin
                  beats_d = (burst_d == '0) ? BURST_LEN'(1) : burst_d;
                  bit_d   = '0;
                  if (is_read_q) begin
                     delay_d = s_slave_delay;
                     split_d = (s_slave_delay >= SPLIT_THR);
                     state_d = (s_slave_delay == '0) ? StRfetch : StRdelay;
                  end else begin
                     state_d = StWdata;
                  end
               end
            end
         end
         StWdata: begin
            if (take_in) begin
               wdata_d = {s_rx_data, wdata_q[DATA_LEN-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            mem_we  = 1'b1;
            addr_d  = addr_q + 1'b1;
            beats_d = beats_q - 1'b1;
            state_d = (beats_q == BURST_LEN'(1)) ? StIdle : StWdata;
         end
         StRdelay: begin
            // Entered only with a non-zero delay, so this state lasts exactly delay_q cycles.
            if (delay_q == DELAY_W'(1)) begin
               state_d = StRfetch;
            end else begin
               delay_d = delay_q - 1'b1;
            end
         end
         StRfetch: begin
            mem_re  = 1'b1;
            state_d = StRdata;
         end
         StRdata: begin
            if (take_out) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  addr_d  = addr_q + 1'b1;
                  beats_d = beats_q - 1'b1;
                  if (beats_q == BURST_LEN'(1)) begin
                     state_d = StIdle;
                  end else begin
                     delay_d = s_slave_delay;
                     split_d = (s_slave_delay >= SPLIT_THR);
                     state_d = (s_slave_delay == '0) ? StRfetch : StRdelay;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         burst_q   <= '0;
         beats_q   <= '0;
         wdata_q   <= '0;
         bit_q     <= '0;
         delay_q   <= '0;
         is_read_q <= 1'b0;
         split_q   <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         burst_q   <= burst_d;
         beats_q   <= beats_d;
         wdata_q   <= wdata_d;
         bit_q     <= bit_d;
         delay_q   <= delay_d;
         is_read_q <= is_read_d;
         split_q   <= split_d;
         ready_q   <= (state_d == StIdle) || (state_d == StAddr) || (state_d == StWdata);
      end
   end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder: writes, burst wrap, read delay/split, stall, bad op,
// and reset in the middle of a write beat.
module tb_bus_slave_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] s_slave_delay;
   logic       s_read_en;
   logic       s_write_en;
   logic       s_master_valid;
   logic       s_master_ready;
   logic       s_rx_address;
   logic       s_rx_burst;
   logic       s_rx_data;
   logic       s_slave_ready;
   logic       s_slave_valid;
   logic       s_tx_data;
   logic       s_split_en;

   int errors = 0;
   int checks = 0;

   bus_slave_responder dut (
      .clk            (clk),
      .reset          (reset),
      .s_slave_delay  (s_slave_delay),
      .s_read_en      (s_read_en),
      .s_write_en     (s_write_en),
      .s_master_valid (s_master_valid),
      .s_master_ready (s_master_ready),
      .s_rx_address   (s_rx_address),
      .s_rx_burst     (s_rx_burst),
      .s_rx_data      (s_rx_data),
      .s_slave_ready  (s_slave_ready),
      .s_slave_valid  (s_slave_valid),
      .s_tx_data      (s_tx_data),
      .s_split_en     (s_split_en)
   );

   always #5 clk = ~clk;

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send_bit(input logic a, input logic b, input logic d, input logic re,
                           input logic we);
      int guard;
      guard          = 0;
      s_rx_address   = a;
      s_rx_burst     = b;
      s_rx_data      = d;
      s_read_en      = re;
      s_write_en     = we;
      s_master_valid = 1'b1;
      while (!s_slave_ready && guard < 64) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!s_slave_ready) begin
         errors++;
         checks++;
         $display("FAIL send_bit_timeout: s_slave_ready=%b required 1", s_slave_ready);
      end
      @(posedge clk); #1;
      s_master_valid = 1'b0;
      s_read_en      = 1'b0;
      s_write_en     = 1'b0;
   endtask

   task automatic send_header(input logic re, input logic we, input logic [11:0] addr,
                              input logic [11:0] burst);
      for (int i = 0; i < 12; i++) begin
         send_bit(addr[i], burst[i], 1'b0, (i == 0) ? re : 1'b0, (i == 0) ? we : 1'b0);
      end
   endtask

   task automatic send_word(input logic [7:0] data);
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b0, 1'b0, data[i], 1'b0, 1'b0);
      end
   endtask

   // n = samples taken before s_slave_valid seen; the first sample is the cycle after the
   // last address bit, so cycles from that bit's cycle to first valid = n + 1.
   task automatic wait_valid(output int n, output int split_cycles);
      n            = 0;
      split_cycles = 0;
      while (!s_slave_valid && n < 200) begin
         if (s_split_en) split_cycles++;
         @(posedge clk); #1;
         n++;
      end
      if (!s_slave_valid) begin
         errors++;
         checks++;
         $display("FAIL wait_valid_timeout: s_slave_valid=0 required 1");
      end
   endtask

   task automatic recv_word(output logic [7:0] w, input int stall_bit, output int hold_bad);
      int guard;
      w        = '0;
      hold_bad = 0;
      for (int i = 0; i < 8; i++) begin
         guard = 0;
         while (!s_slave_valid && guard < 64) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!s_slave_valid) begin
            errors++;
            checks++;
            $display("FAIL recv_timeout bit %0d: s_slave_valid=0 required 1", i);
            return;
         end
         w[i] = s_tx_data;
         if (i == stall_bit) begin
            s_master_ready = 1'b0;
            repeat (4) begin
               @(posedge clk); #1;
               if (s_tx_data !== w[i] || s_slave_valid !== 1'b1) hold_bad++;
            end
            s_master_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      s_slave_delay  = '0;
      s_read_en      = 1'b0;
      s_write_en     = 1'b0;
      s_master_valid = 1'b0;
      s_master_ready = 1'b1;
      s_rx_address   = 1'b0;
      s_rx_burst     = 1'b0;
      s_rx_data      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 4;
      if (s_slave_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_slave_ready); end
      if (s_slave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_slave_valid); end
      if (s_tx_data !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b want 0", s_tx_data); end
      if (s_split_en !== 1'b0) begin errors++; $display("FAIL reset_split: got %b want 0", s_split_en); end
      reset = 1'b0;
      #1;
      checks++;
      if (s_slave_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", s_slave_ready); end
      @(posedge clk); #1;
      checks++;
      if (s_slave_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", s_slave_ready); end
   endtask

   task automatic test_write_read();
      logic [7:0] w;
      int n, sp, hb;
      send_header(1'b0, 1'b1, 12'h005, 12'd1);
      send_word(8'hA5);
      checks++;
      if (s_slave_ready !== 1'b0) begin errors++; $display("FAIL write_cycle_ready: got %b want 0", s_slave_ready); end
      @(posedge clk); #1;
      checks++;
      if (s_slave_ready !== 1'b1) begin errors++; $display("FAIL after_write_ready: got %b want 1", s_slave_ready); end
      s_slave_delay = 6'd0;
      send_header(1'b1, 1'b0, 12'h005, 12'd1);
      wait_valid(n, sp);
      checks++;
      if (n + 1 != 2) begin errors++; $display("FAIL latency_d0: got %0d want 2", n + 1); end
      recv_word(w, -1, hb);
      checks++;
      if (w !== 8'hA5) begin errors++; $display("FAIL read_a5: got %h want a5", w); end
      checks++;
      if (s_slave_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b want 0", s_slave_valid); end
   endtask

   task automatic test_burst_wrap();
      logic [7:0] w;
      logic [7:0] exp3 [3];
      int n, sp, hb;
      exp3[0] = 8'h11;
      exp3[1] = 8'h22;
      exp3[2] = 8'h33;
      send_header(1'b0, 1'b1, 12'hFFF, 12'd3);
      for (int k = 0; k < 3; k++) send_word(exp3[k]);
      s_slave_delay = 6'd0;
      send_header(1'b1, 1'b0, 12'hFFF, 12'd3);
      wait_valid(n, sp);
      for (int k = 0; k < 3; k++) begin
         recv_word(w, -1, hb);
         checks++;
         if (w !== exp3[k]) begin errors++; $display("FAIL burst_fff beat %0d: got %h want %h", k, w, exp3[k]); end
      end
      checks++;
      if (s_slave_valid !== 1'b0) begin errors++; $display("FAIL burst_end_valid: got %b want 0", s_slave_valid); end
      send_header(1'b1, 1'b0, 12'h000, 12'd2);
      for (int k = 1; k < 3; k++) begin
         recv_word(w, -1, hb);
         checks++;
         if (w !== exp3[k]) begin errors++; $display("FAIL wrap_000 beat %0d: got %h want %h", k, w, exp3[k]); end
      end
   endtask

   task automatic test_delay3();
      logic [7:0] w;
      int n, sp, hb;
      s_slave_delay = 6'd3;
      send_header(1'b1, 1'b0, 12'h005, 12'd1);
      wait_valid(n, sp);
      checks += 2;
      if (n + 1 != 5) begin errors++; $display("FAIL latency_d3: got %0d want 5", n + 1); end
      if (sp != 0) begin errors++; $display("FAIL split_d3: got %0d cycles want 0", sp); end
      recv_word(w, -1, hb);
      checks++;
      if (w !== 8'hA5) begin errors++; $display("FAIL read_d3: got %h want a5", w); end
   endtask

   task automatic test_split();
      logic [7:0] w;
      int n, sp, hb;
      s_slave_delay = 6'd10;
      send_header(1'b1, 1'b0, 12'h005, 12'd1);
      wait_valid(n, sp);
      checks += 3;
      if (sp != 10) begin errors++; $display("FAIL split_cycles: got %0d want 10", sp); end
      if (s_split_en !== 1'b0) begin errors++; $display("FAIL split_at_valid: got %b want 0", s_split_en); end
      if (n + 1 != 12) begin errors++; $display("FAIL latency_d10: got %0d want 12", n + 1); end
      recv_word(w, -1, hb);
      checks++;
      if (w !== 8'hA5) begin errors++; $display("FAIL read_d10: got %h want a5", w); end
   endtask

   task automatic test_stall();
      logic [7:0] w;
      int n, sp, hb;
      s_slave_delay = 6'd0;
      send_header(1'b1, 1'b0, 12'hFFF, 12'd1);
      recv_word(w, 3, hb);
      checks += 2;
      if (hb != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", hb); end
      if (w !== 8'h11) begin errors++; $display("FAIL stall_word: got %h want 11", w); end
   endtask

   task automatic test_bad_op();
      logic [7:0] w;
      logic [11:0] a;
      int hb;
      a = 12'h005;
      for (int i = 0; i < 12; i++) send_bit(a[i], 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      checks += 2;
      if (s_slave_ready !== 1'b1) begin errors++; $display("FAIL badop_ready: got %b want 1", s_slave_ready); end
      if (s_slave_valid !== 1'b0) begin errors++; $display("FAIL badop_valid: got %b want 0", s_slave_valid); end
      s_slave_delay = 6'd0;
      send_header(1'b1, 1'b0, 12'h005, 12'd1);
      recv_word(w, -1, hb);
      checks++;
      if (w !== 8'hA5) begin errors++; $display("FAIL badop_mem: got %h want a5", w); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] w;
      logic [7:0] d;
      int hb;
      d = 8'h3C;
      send_header(1'b0, 1'b1, 12'h005, 12'd1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, d[i], 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checks += 4;
      if (s_slave_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", s_slave_ready); end
      if (s_slave_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", s_slave_valid); end
      if (s_tx_data !== 1'b0) begin errors++; $display("FAIL midreset_tx: got %b want 0", s_tx_data); end
      if (s_split_en !== 1'b0) begin errors++; $display("FAIL midreset_split: got %b want 0", s_split_en); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      s_slave_delay = 6'd0;
      send_header(1'b1, 1'b0, 12'h005, 12'd1);
      recv_word(w, -1, hb);
      checks++;
      if (w !== 8'hA5) begin errors++; $display("FAIL midreset_mem: got %h want a5", w); end
   endtask

   initial begin
      #1;
      test_reset();
      test_write_read();
      test_burst_wrap();
      test_delay3();
      test_split();
      test_stall();
      test_bad_op();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
